// File: rtl/framebuf_arbiter.sv
// rtl/framebuf_arbiter.sv - SPRAM frame-buffer arbiter: VGA reads pre-empt a small camera write FIFO.
// Optional feature macro: FBA_DROP_COUNT_EN adds the saturating drop_cnt output.
module framebuf_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_do
`ifdef FBA_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    G_IDLE,
    G_READ,
    G_WRITE
  } grant_e;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] ram_ad_q;
  logic [DATA_W-1:0] ram_di_q;
  logic              ram_we_q;
  logic              rd_pend_q;
  logic              rd_valid_q;
  logic              frame_done_q;
  logic              overflow_q;

  grant_e            grant;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drop;
  logic [PTR_W-1:0]  push_slot;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign wr_ready   = !fifo_full && rst_n;
  assign push       = wr_valid && wr_ready;
  assign drop       = wr_valid && !wr_ready && rst_n;

  always_comb begin
    grant = G_IDLE;
    if (rd_req) begin
      grant = G_READ;
    end else if (!fifo_empty) begin
      grant = G_WRITE;
    end
  end

  // A frame restart cancels the pending write so stale pixels never land in the new frame.
  assign pop       = (grant == G_WRITE) && !frame_start;
  assign push_slot = frame_start ? '0 : wr_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (frame_start) begin
      rd_ptr_d = '0;
      wr_ptr_d = push ? PTR_ONE : '0;
      cnt_d    = push ? CNT_ONE : '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    if (frame_start) begin
      wr_addr_d = '0;
    end else if (pop) begin
      wr_addr_d = (wr_addr_q == ADDR_LAST) ? '0 : wr_addr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[push_slot] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      ram_ad_q     <= '0;
      ram_di_q     <= '0;
      ram_we_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      wr_addr_q    <= wr_addr_d;
      rd_pend_q    <= rd_req;
      rd_valid_q   <= rd_pend_q;
      ram_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      case (grant)
        G_READ: begin
          ram_ad_q <= rd_addr;
        end
        G_WRITE: begin
          if (pop) begin
            ram_ad_q     <= wr_addr_q;
            ram_di_q     <= fifo_mem[rd_ptr_q];
            ram_we_q     <= 1'b1;
            frame_done_q <= (wr_addr_q == ADDR_LAST);
          end
        end
        default: begin
        end
      endcase
      if (frame_start) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef FBA_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign ram_ad     = ram_ad_q;
  assign ram_di     = ram_di_q;
  assign ram_we     = ram_we_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = ram_do;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_framebuf_arbiter.sv
// tb/tb_framebuf_arbiter.sv - directed self-checking bench for framebuf_arbiter (FRAME_WORDS=8).
module tb_framebuf_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        frame_done;
  logic        overflow;
  logic [13:0] ram_ad;
  logic [15:0] ram_di;
  logic        ram_we;
  logic [15:0] ram_do;
`ifdef FBA_DROP_COUNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  framebuf_arbiter #(
    .ADDR_W(14), .DATA_W(16), .FIFO_DEPTH(4), .FRAME_WORDS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .frame_done(frame_done), .overflow(overflow),
    .ram_ad(ram_ad), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do)
`ifdef FBA_DROP_COUNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SPRAM stand-in: registered DO, reads return 0x5000 ^ address.
  always @(posedge clk) begin
    ram_do <= ram_we ? ram_di : (16'h5000 ^ {2'b00, ram_ad});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame_start = 1'b0; wr_valid = 1'b1; wr_data = 16'h1234;
    rd_req = 1'b0; rd_addr = '0;
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we[%0d] got=%b exp=0", i, ram_we); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow[%0d] got=%b exp=0", i, overflow); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid[%0d] got=%b exp=0", i, rd_valid); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done[%0d] got=%b exp=0", i, frame_done); end
      n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready_hold[%0d] got=%b exp=0", i, wr_ready); end
    end
    rst_n = 1'b1; wr_valid = 1'b0;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_wr_ready got=%b exp=1", wr_ready); end
    tick();
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_no_push got ram_we=%b exp=0", ram_we); end
  endtask

  task automatic test_writes_idle;
    for (int j = 0; j < 5; j++) begin
      wr_valid = (j < 3);
      wr_data  = 16'hA001 + 16'(j);
      tick();
      if (j >= 1 && j <= 3) begin
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL idle_write_we[%0d] got=%b exp=1", j, ram_we); end
        n_cmp++; if (ram_ad !== 14'(j - 1)) begin n_err++; $display("FAIL idle_write_ad[%0d] got=%0d exp=%0d", j, ram_ad, j - 1); end
        n_cmp++; if (ram_di !== 16'hA000 + 16'(j)) begin n_err++; $display("FAIL idle_write_di[%0d] got=%h exp=%h", j, ram_di, 16'hA000 + 16'(j)); end
      end else begin
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL idle_write_quiet[%0d] got=%b exp=0", j, ram_we); end
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_read_priority;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      rd_req   = (c < 4);
      rd_addr  = 14'(5 + c);
      wr_valid = (c < 2);
      wr_data  = 16'hB001 + 16'(c);
      tick();
      if (c < 4) begin
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rdpri_no_we[%0d] got=%b exp=0", c, ram_we); end
        n_cmp++; if (ram_ad !== 14'(5 + c)) begin n_err++; $display("FAIL rdpri_ad[%0d] got=%0d exp=%0d", c, ram_ad, 5 + c); end
      end
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rdpri_valid[%0d] got=%b exp=1", c, rd_valid); end
        n_cmp++; if (rd_data !== (16'h5000 ^ 16'(4 + c))) begin n_err++; $display("FAIL rdpri_data[%0d] got=%h exp=%h", c, rd_data, 16'h5000 ^ 16'(4 + c)); end
      end else begin
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rdpri_novalid[%0d] got=%b exp=0", c, rd_valid); end
      end
      if (c == 4 || c == 5) begin
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL rdpri_drain_we[%0d] got=%b exp=1", c, ram_we); end
        n_cmp++; if (ram_ad !== 14'(c - 4)) begin n_err++; $display("FAIL rdpri_drain_ad[%0d] got=%0d exp=%0d", c, ram_ad, c - 4); end
        n_cmp++; if (ram_di !== 16'hB001 + 16'(c - 4)) begin n_err++; $display("FAIL rdpri_drain_di[%0d] got=%h exp=%h", c, ram_di, 16'hB001 + 16'(c - 4)); end
      end
      if (c == 6) begin
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rdpri_drained got=%b exp=0", ram_we); end
      end
    end
    rd_req = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_overflow;
    rd_req = 1'b1; rd_addr = 14'd3;
    for (int k = 0; k < 6; k++) begin
      wr_valid = 1'b1;
      wr_data  = 16'hC100 + 16'(k);
      #1;
      n_cmp++; if (wr_ready !== (k < 4)) begin n_err++; $display("FAIL ovf_wr_ready[%0d] got=%b exp=%b", k, wr_ready, (k < 4)); end
      tick();
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL ovf_no_we[%0d] got=%b exp=0", k, ram_we); end
      n_cmp++; if (overflow !== (k >= 4)) begin n_err++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", k, overflow, (k >= 4)); end
    end
    wr_valid = 1'b0;
`ifdef FBA_DROP_COUNT_EN
    n_cmp++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    rd_req = 1'b0;
  endtask

  task automatic test_wrap;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wrap_fs_cancel got=%b exp=0", ram_we); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_fs_ovf_clear got=%b exp=0", overflow); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wrap_fs_flush got=%b exp=1", wr_ready); end
    for (int j = 0; j < 11; j++) begin
      wr_valid = (j < 9);
      wr_data  = 16'hC000 + 16'(j);
      tick();
      if (j >= 1 && j <= 9) begin
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL wrap_we[%0d] got=%b exp=1", j, ram_we); end
        n_cmp++; if (ram_ad !== 14'((j - 1) % 8)) begin n_err++; $display("FAIL wrap_ad[%0d] got=%0d exp=%0d", j, ram_ad, (j - 1) % 8); end
        n_cmp++; if (ram_di !== 16'hC000 + 16'(j - 1)) begin n_err++; $display("FAIL wrap_di[%0d] got=%h exp=%h", j, ram_di, 16'hC000 + 16'(j - 1)); end
      end else begin
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wrap_quiet[%0d] got=%b exp=0", j, ram_we); end
      end
      n_cmp++; if (frame_done !== (j == 8)) begin n_err++; $display("FAIL wrap_frame_done[%0d] got=%b exp=%b", j, frame_done, (j == 8)); end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_frame_start;
    rd_req = 1'b1; rd_addr = 14'd2;
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1;
      wr_data  = 16'hD001 + 16'(k);
      tick();
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fs_ovf_set got=%b exp=1", overflow); end
    rd_req = 1'b0; wr_valid = 1'b0;
    tick();
    n_cmp++; if (ram_we !== 1'b1 || ram_ad !== 14'd1 || ram_di !== 16'hD001) begin
      n_err++; $display("FAIL fs_predrain got we=%b ad=%0d di=%h exp we=1 ad=1 di=d001", ram_we, ram_ad, ram_di);
    end
    frame_start = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF;
    tick();
    frame_start = 1'b0; wr_valid = 1'b0;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL fs_cancel_we got=%b exp=0", ram_we); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fs_ovf_clear got=%b exp=0", overflow); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fs_wr_ready got=%b exp=1", wr_ready); end
    tick();
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL fs_first_we got=%b exp=1", ram_we); end
    n_cmp++; if (ram_ad !== 14'd0) begin n_err++; $display("FAIL fs_first_ad got=%0d exp=0", ram_ad); end
    n_cmp++; if (ram_di !== 16'hBEEF) begin n_err++; $display("FAIL fs_first_di got=%h exp=beef", ram_di); end
    tick();
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL fs_count_one got=%b exp=0", ram_we); end
  endtask

  initial begin
    test_reset();
    test_writes_idle();
    test_read_priority();
    test_overflow();
    test_wrap();
    test_frame_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
